// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg -- shared constants and control decode for the baud tick generator.
//
// Contents:
//   MIN_DIV        smallest integer divisor a runtime load may install
//   DEF_DIV_9600   integer divisor for 9600 baud x16 from a 50 MHz clock
//   DEF_FRAC_9600  fractional divisor (sixteenths) for the same rate (325.5)
//   ctl_e          per-cycle action chosen for the counters
//   decode_ctl     priority decode: load > clear > enable-gated count
// -----------------------------------------------------------------------------
package baud_pkg;

  localparam int MIN_DIV       = 2;
  localparam int DEF_DIV_9600  = 325;
  localparam int DEF_FRAC_9600 = 8;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,  // enable low: everything frozen
    CTL_COUNT = 2'd1,  // advance the cycle counter
    CTL_CLEAR = 2'd2,  // restart phase, keep divisor
    CTL_LOAD  = 2'd3   // install new divisor and restart phase
  } ctl_e;

  // A rejected load is not passed in as load_ok, so it falls through to
  // whatever sync_clear / enable request; the old divisor keeps its timing.
  function automatic ctl_e decode_ctl(input logic load_ok,
                                      input logic clear,
                                      input logic en);
    if (load_ok) return CTL_LOAD;
    if (clear)   return CTL_CLEAR;
    if (en)      return CTL_COUNT;
    return CTL_IDLE;
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// -----------------------------------------------------------------------------
// baud_tick_gen_if -- control and tick bundle of the baud tick generator.
//
// master (controller side) drives:
//   enable, sync_clear, div_load, div_in[DIV_W], frac_in[FRAC_W]
// slave (generator side) drives:
//   os_tick, mid_tick, bit_tick, os_phase[PH_W], cfg_err
// -----------------------------------------------------------------------------
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int PH_W   = 4
);

  logic              enable;
  logic              sync_clear;
  logic              div_load;
  logic [DIV_W-1:0]  div_in;
  logic [FRAC_W-1:0] frac_in;

  logic              os_tick;
  logic              mid_tick;
  logic              bit_tick;
  logic [PH_W-1:0]   os_phase;
  logic              cfg_err;

  modport master (
    output enable, sync_clear, div_load, div_in, frac_in,
    input  os_tick, mid_tick, bit_tick, os_phase, cfg_err
  );

  modport slave (
    input  enable, sync_clear, div_load, div_in, frac_in,
    output os_tick, mid_tick, bit_tick, os_phase, cfg_err
  );

endinterface

// File: rtl/baud_frac_acc.sv
// -----------------------------------------------------------------------------
// baud_frac_acc -- fractional accumulator and interval-length decision.
//
// Ports:
//   clk_in, reset   clock and asynchronous active-high reset
//   clear_i         zero accumulator and pending extension (phase restart)
//   tick_i          an os_tick is being issued this cycle
//   frac_i          fractional divisor added per os_tick (mod 2^FRAC_W)
//   div_i           integer divisor
//   cnt_i           current cycle count within the interval
//   period_end_o    cnt_i is the last cycle of the current interval
//
// The carry from the add done at an os_tick is held in ext_q and stretches
// the following interval from div_i to div_i+1 cycles.
// -----------------------------------------------------------------------------
module baud_frac_acc #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              tick_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [DIV_W-1:0]  cnt_i,
  output logic              period_end_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [FRAC_W:0]   sum;
  logic [DIV_W:0]    last_cnt;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac_i};
    acc_d = acc_q;
    ext_d = ext_q;
    if (clear_i) begin
      acc_d = '0;
      ext_d = 1'b0;
    end else if (tick_i) begin
      acc_d = sum[FRAC_W-1:0];
      ext_d = sum[FRAC_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ext_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ext_q <= ext_d;
    end
  end

  // Divisor is always >= 2, so the subtraction cannot underflow.
  assign last_cnt     = {1'b0, div_i} - {{DIV_W{1'b0}}, 1'b1}
                      + {{DIV_W{1'b0}}, ext_q};
  assign period_end_o = ({1'b0, cnt_i} == last_cnt);

endmodule

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen -- fractional-N baud tick generator for a UART.
//
// Ports:
//   clk_in   single clock, rising edge
//   reset    asynchronous, active-high; restores DEF_DIV / DEF_FRAC
//   bus      baud_tick_gen_if.slave:
//              enable      counters advance only while high
//              sync_clear  restart phase (RX start-bit alignment)
//              div_load    strobe capturing div_in / frac_in
//              os_tick     oversample pulse, every div or div+1 cycles
//              mid_tick    os_tick moving os_phase OSR/2-1 -> OSR/2
//              bit_tick    os_tick wrapping os_phase OSR-1 -> 0
//              os_phase    current oversample index
//              cfg_err     pulse when a load with div_in < MIN_DIV is rejected
//
// OSR must be a power of two (>= 4) so os_phase wraps by plain overflow.
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_DIV  = DEF_DIV_9600,
  parameter int DEF_FRAC = DEF_FRAC_9600
) (
  input  logic          clk_in,
  input  logic          reset,
  baud_tick_gen_if.slave bus
);

  localparam int              PH_W      = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_MID_M1 = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OSR - 1);

  logic [DIV_W-1:0]  div_q,   div_d;
  logic [FRAC_W-1:0] frac_q,  frac_d;
  logic [DIV_W-1:0]  cnt_q,   cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              os_q,  os_d;
  logic              mid_q, mid_d;
  logic              bit_q, bit_d;
  logic              err_q, err_d;

  logic load_ok;
  logic load_bad;
  ctl_e ctl;
  logic period_end;
  logic tick_ev;
  logic acc_clear;

  assign load_ok   = bus.div_load && (bus.div_in >= DIV_W'(MIN_DIV));
  assign load_bad  = bus.div_load && !load_ok;
  assign ctl       = decode_ctl(load_ok, bus.sync_clear, bus.enable);
  assign tick_ev   = (ctl == CTL_COUNT) && period_end;
  assign acc_clear = (ctl == CTL_LOAD) || (ctl == CTL_CLEAR);

  baud_frac_acc #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk_in       (clk_in),
    .reset        (reset),
    .clear_i      (acc_clear),
    .tick_i       (tick_ev),
    .frac_i       (frac_q),
    .div_i        (div_q),
    .cnt_i        (cnt_q),
    .period_end_o (period_end)
  );

  always_comb begin
    div_d   = div_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    os_d    = 1'b0;
    mid_d   = 1'b0;
    bit_d   = 1'b0;
    err_d   = load_bad;
    unique case (ctl)
      CTL_LOAD: begin
        div_d   = bus.div_in;
        frac_d  = bus.frac_in;
        cnt_d   = '0;
        phase_d = '0;
      end
      CTL_CLEAR: begin
        cnt_d   = '0;
        phase_d = '0;
      end
      CTL_COUNT: begin
        if (period_end) begin
          cnt_d   = '0;
          phase_d = phase_q + 1'b1;
          os_d    = 1'b1;
          mid_d   = (phase_q == PH_MID_M1);
          bit_d   = (phase_q == PH_LAST);
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: ;  // CTL_IDLE: hold everything, no ticks
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_q   <= DIV_W'(DEF_DIV);
      frac_q  <= FRAC_W'(DEF_FRAC);
      cnt_q   <= '0;
      phase_q <= '0;
      os_q    <= 1'b0;
      mid_q   <= 1'b0;
      bit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      os_q    <= os_d;
      mid_q   <= mid_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
    end
  end

  assign bus.os_tick  = os_q;
  assign bus.mid_tick = mid_q;
  assign bus.bit_tick = bit_q;
  assign bus.os_phase = phase_q;
  assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_gen -- self-checking bench for baud_tick_gen.
//
// Reference model: counts enabled cycles since the last phase restart and
// places the k-th os_tick at k*div + floor((k-1)*frac / 2^FRAC_W), i.e. the
// number of accumulator carries produced by the first k-1 additions.
// -----------------------------------------------------------------------------
module tb_baud_tick_gen;

  localparam int DIV_W    = 8;
  localparam int FRAC_W   = 2;
  localparam int OSR      = 4;
  localparam int PH_W     = 2;
  localparam int DEF_DIV  = 5;
  localparam int DEF_FRAC = 1;

  logic clk_in;
  logic reset;

  baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .PH_W(PH_W)) bus ();

  baud_tick_gen #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .OSR      (OSR),
    .DEF_DIV  (DEF_DIV),
    .DEF_FRAC (DEF_FRAC)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state.
  int m_div, m_frac, m_e, m_n;
  bit e_os, e_mid, e_bit, e_err;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int tick_time(input int k);
    return k * m_div + ((k - 1) * m_frac) / (1 << FRAC_W);
  endfunction

  function automatic logic [31:0] dut_outs();
    return {26'd0, bus.os_tick, bus.mid_tick, bus.bit_tick, bus.cfg_err,
            bus.os_phase};
  endfunction

  function automatic logic [31:0] exp_outs();
    logic [1:0] ph;
    ph = 2'(m_n % OSR);
    return {26'd0, e_os, e_mid, e_bit, e_err, ph};
  endfunction

  task automatic model_reset();
    m_div = DEF_DIV; m_frac = DEF_FRAC; m_e = 0; m_n = 0;
    e_os = 0; e_mid = 0; e_bit = 0; e_err = 0;
  endtask

  task automatic model_edge();
    int din;
    din   = int'(bus.div_in);
    e_os  = 0; e_mid = 0; e_bit = 0;
    e_err = bus.div_load && (din < 2);
    if (bus.div_load && din >= 2) begin
      m_div = din; m_frac = int'(bus.frac_in); m_e = 0; m_n = 0;
    end else if (bus.sync_clear) begin
      m_e = 0; m_n = 0;
    end else if (bus.enable) begin
      m_e++;
      if (m_e == tick_time(m_n + 1)) begin
        e_os  = 1;
        e_mid = (m_n % OSR) == (OSR / 2 - 1);
        e_bit = (m_n % OSR) == (OSR - 1);
        m_n++;
      end
    end
  endtask

  task automatic drive(input bit en, input bit sc, input bit ld,
                       input int din, input int fin);
    bus.enable     = en;
    bus.sync_clear = sc;
    bus.div_load   = ld;
    bus.div_in     = DIV_W'(din);
    bus.frac_in    = FRAC_W'(fin);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk_in);
    if (!reset) model_edge();
    cyc++;
    #1;
    check("model", dut_outs(), exp_outs());
  endtask

  // Runs ncyc cycles with current inputs; os_tick expected only at tick_idx.
  task automatic run_os(input string tag, input int ncyc, input int tick_idx);
    for (int k = 1; k <= ncyc; k++) begin
      cycle();
      check(tag, 32'(bus.os_tick), 32'(k == tick_idx));
    end
  endtask

  // Called 1 time unit after an edge; releases 1 time unit after an edge.
  task automatic apply_reset(input int hold);
    reset = 1'b1;
    #1;
    check("rst_async", dut_outs(), 32'd0);
    model_reset();
    repeat (hold) @(posedge clk_in);
    #1;
    check("rst_hold", dut_outs(), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks[$];
    int exp_ticks[8] = '{4, 8, 13, 17, 22, 26, 31, 35};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("reset_state", dut_outs(), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;

    // Default divisor from reset, then reset mid-bit and restart.
    drive(1, 0, 0, 0, 0);
    run_os("def_first", 5, 5);
    check("def_phase", 32'(bus.os_phase), 32'd1);
    apply_reset(2);
    run_os("def_restart", 5, 5);

    // div=4 frac=0: ticks every 4, mid at 8, bit at 16.
    drive(1, 0, 1, 4, 0);
    cycle();
    check("load_no_tick", 32'(bus.os_tick), 32'd0);
    drive(1, 0, 0, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      cycle();
      check("d4_os",  32'(bus.os_tick),  32'(c % 4 == 0));
      check("d4_mid", 32'(bus.mid_tick), 32'(c == 8));
      check("d4_bit", 32'(bus.bit_tick), 32'(c == 16));
    end

    // Rejected load: one-cycle cfg_err, spacing stays at 4.
    drive(1, 0, 1, 1, 3);
    cycle();
    check("cfg_err_hi", 32'(bus.cfg_err), 32'd1);
    drive(1, 0, 0, 0, 0);
    cycle();
    check("cfg_err_lo", 32'(bus.cfg_err), 32'd0);
    run_os("bad_load_gap", 2, 2);
    run_os("bad_load_next", 4, 4);

    // sync_clear at os_phase 2, third cycle of the interval.
    check("pre_clr_phase", 32'(bus.os_phase), 32'd2);
    run_os("pre_clr", 2, 0);
    drive(1, 1, 0, 0, 0);
    cycle();
    check("clr_no_tick", 32'(bus.os_tick), 32'd0);
    check("clr_phase",   32'(bus.os_phase), 32'd0);
    drive(1, 0, 0, 0, 0);
    run_os("post_clr", 4, 4);
    check("post_clr_phase", 32'(bus.os_phase), 32'd1);

    // Enable low for 10 cycles mid-interval; remaining 2 cycles then complete.
    run_os("pre_dis", 2, 0);
    drive(0, 0, 0, 0, 0);
    run_os("dis", 10, 0);
    check("dis_phase", 32'(bus.os_phase), 32'd1);
    drive(1, 0, 0, 0, 0);
    run_os("resume", 2, 2);
    check("resume_phase", 32'(bus.os_phase), 32'd2);

    // div=4 frac=2/4: 8 ticks within 36 cycles, carries stretch every other.
    drive(1, 0, 1, 4, 2);
    cycle();
    drive(1, 0, 0, 0, 0);
    for (int c = 1; c <= 36; c++) begin
      cycle();
      if (bus.os_tick) ticks.push_back(c);
    end
    check("frac_count", 32'(ticks.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frac_tick%0d", i),
            (i < ticks.size()) ? 32'(ticks[i]) : 32'hFFFF_FFFF,
            32'(exp_ticks[i]));
    end

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset(1);
      drive($urandom_range(0, 99) < 85,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 2,
            int'($urandom_range(0, 9)),
            int'($urandom_range(0, 3)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4, width of the fractional divisor.
REQ-003 SHALL have parameter OSR, default 16, oversample ticks per bit; power of two, minimum 4.
REQ-004 SHALL have parameter DEF_DIV, default 325, integer divisor loaded at reset.
REQ-005 SHALL have parameter DEF_FRAC, default 8, fractional divisor loaded at reset (325.5 ~ 50 MHz / (9600*16)).
REQ-006 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port enable, input, 1, counters advance only while high.
REQ-009 SHALL have port sync_clear, input, 1, restarts phase (RX start-bit alignment).
REQ-010 SHALL have port div_load, input, 1, single-cycle strobe capturing div_in and frac_in.
REQ-011 SHALL have ports div_in, input, DIV_W, and frac_in, input, FRAC_W, the new divisor.
REQ-012 SHALL have port os_tick, output, 1, one-cycle oversample pulse.
REQ-013 SHALL have port mid_tick, output, 1, one-cycle mid-bit sample pulse.
REQ-014 SHALL have port bit_tick, output, 1, one-cycle bit-period pulse.
REQ-015 SHALL have port os_phase, output, log2(OSR), current oversample index.
REQ-016 SHALL have port cfg_err, output, 1, one-cycle pulse on a rejected load.

Function
REQ-017 SHALL hold div_reg/frac_reg; the effective period of each os_tick interval is div_reg, or div_reg+1 when the fractional accumulator carries.
REQ-018 SHALL add frac_reg to a FRAC_W-bit accumulator (modulo 2^FRAC_W) at each os_tick; a carry-out lengthens the next interval by one cycle.
REQ-019 SHALL register all outputs; with enable high from reset release and frac_reg=0, os_tick is high in cycles div_reg, 2*div_reg, ... (cycle 1 = first edge after reset release).
REQ-020 SHALL increment os_phase modulo OSR on each os_tick; it wraps OSR-1 -> 0.
REQ-021 SHALL assert bit_tick coincident with the os_tick that wraps os_phase OSR-1 -> 0.
REQ-022 SHALL assert mid_tick coincident with the os_tick that moves os_phase from OSR/2-1 to OSR/2.
REQ-023 SHALL freeze the cycle counter, os_phase and accumulator while enable is low; no ticks are emitted; counting resumes from the frozen value.
REQ-024 SHALL, on sync_clear, zero the cycle counter, os_phase and accumulator, and suppress all ticks that cycle.
REQ-025 SHALL, on div_load with div_in >= 2, update div_reg/frac_reg and apply the same clearing as sync_clear.
REQ-026 SHALL, on div_load with div_in < 2, leave all registers and counters unchanged and pulse cfg_err for one cycle.
REQ-027 SHALL apply priority reset > div_load > sync_clear > enable-gated counting; a valid div_load with sync_clear performs one clear.
REQ-028 SHALL never emit two os_ticks less than div_reg cycles apart.

Reset
REQ-029 SHALL, on reset, set div_reg=DEF_DIV, frac_reg=DEF_FRAC, counters and accumulator to 0, and all outputs to 0, immediately and asynchronously.
REQ-030 SHALL, when reset is asserted mid-interval, discard the partial count; the first tick after release follows REQ-019.

Structure
REQ-031 SHALL take MIN_DIV=2 and the default 9600-baud divisor constants from shared package baud_pkg.
REQ-032 SHALL implement the fractional accumulator plus period-extension logic as sub-module baud_frac_acc.

Verification
REQ-033 SHALL cover: DIV=4, FRAC=0, OSR=4, enable held -> os_tick at cycles 4,8,12,16; mid_tick at 8; bit_tick at 16.
REQ-034 SHALL cover: FRAC_W=2, load div=4 frac=2 -> intervals alternate 4,5; exactly 8 os_ticks in 36 cycles.
REQ-035 SHALL cover: load div_in=1 -> cfg_err high one cycle; tick spacing unchanged at the previous divisor.
REQ-036 SHALL cover: sync_clear at os_phase=2, cycle 3 of 4 -> no tick that cycle; next os_tick 4 cycles later with os_phase 0 -> 1.
REQ-037 SHALL cover: enable low for 10 cycles mid-interval -> no ticks; after re-enable, the remaining count completes without restart.
REQ-038 SHALL cover: reset pulse mid-bit -> outputs 0 immediately; after release, DEF_DIV timing restarts from cycle 1.
